// File: rtl/cursor_pkg.sv
// Shared types and constants for the mouse cursor tracker.
package cursor_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    APPLY = 1'b1
  } state_t;

  localparam int DEF_SCREEN_W = 640;
  localparam int DEF_SCREEN_H = 480;
  localparam int POS_W        = 10;

  localparam int ACC_W   = 11;
  localparam int ACC_MAX = 1023;
  localparam int ACC_MIN = -1024;

  function automatic int clamp(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer for an asynchronous level, plus a rising-edge pulse.
module edge_sync (
  input  logic Clk,
  input  logic Reset,
  input  logic async_in,
  output logic pulse
);

  logic [2:0] sync_q;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) sync_q <= '0;
    else        sync_q <= {sync_q[1:0], async_in};
  end

  // sync_q[2] only remembers the previous synchronized level for edge detect
  assign pulse = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/cursor_tracker.sv
// Accumulates mouse motion, applies it once per frame to a clamped cursor position.
// Shot counter with fire/reload is built only when CURSOR_SHOTS_EN is defined.
module cursor_tracker
  import cursor_pkg::*;
#(
  parameter int SCREEN_W    = DEF_SCREEN_W,
  parameter int SCREEN_H    = DEF_SCREEN_H,
  parameter int CURSOR_SIZE = 4,
  parameter int START_X     = 320,
  parameter int START_Y     = 240,
  parameter int MAX_SHOTS   = 3
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       report_valid,
  output logic       report_ready,
  input  logic [7:0] report_dx,
  input  logic [7:0] report_dy,
  input  logic [7:0] report_buttons,
  input  logic       reload,
  output logic [9:0] BallX,
  output logic [9:0] BallY,
  output logic [9:0] Ball_size,
  output logic [7:0] MouseButtons,
  output logic [1:0] shot_count,
  output logic       shot_fire
);

  logic frame_edge;
  logic xfer;
  state_t state;
  logic signed [ACC_W-1:0] acc_x, acc_y;
  logic signed [ACC_W-1:0] acc_x_nxt, acc_y_nxt;

  edge_sync u_frame_sync (
    .Clk      (Clk),
    .Reset    (Reset),
    .async_in (frame_clk),
    .pulse    (frame_edge)
  );

  assign xfer      = report_valid & report_ready;
  assign Ball_size = POS_W'(CURSOR_SIZE);

  // Screen Y grows downward while mouse dy is positive-up, hence the subtraction.
  always_comb begin
    acc_x_nxt = acc_x;
    acc_y_nxt = acc_y;
    if (xfer) begin
      acc_x_nxt = ACC_W'(clamp(int'(acc_x) + int'($signed(report_dx)), ACC_MIN, ACC_MAX));
      acc_y_nxt = ACC_W'(clamp(int'(acc_y) - int'($signed(report_dy)), ACC_MIN, ACC_MAX));
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state        <= IDLE;
      report_ready <= 1'b1;
      acc_x        <= '0;
      acc_y        <= '0;
      BallX        <= POS_W'(START_X);
      BallY        <= POS_W'(START_Y);
      MouseButtons <= '0;
    end else begin
      case (state)
        IDLE: begin
          acc_x <= acc_x_nxt;
          acc_y <= acc_y_nxt;
          if (xfer) MouseButtons <= report_buttons;
          if (frame_edge) begin
            state        <= APPLY;
            report_ready <= 1'b0;
          end
        end
        APPLY: begin
          BallX <= POS_W'(clamp(int'({2'b00, BallX}) + int'(acc_x),
                                CURSOR_SIZE, SCREEN_W - 1 - CURSOR_SIZE));
          BallY <= POS_W'(clamp(int'({2'b00, BallY}) + int'(acc_y),
                                CURSOR_SIZE, SCREEN_H - 1 - CURSOR_SIZE));
          acc_x        <= '0;
          acc_y        <= '0;
          state        <= IDLE;
          report_ready <= 1'b1;
        end
        default: begin
          state        <= IDLE;
          report_ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef CURSOR_SHOTS_EN
  logic fire_edge;

  // MouseButtons still holds the previous accepted report when the new one transfers
  assign fire_edge = xfer & report_buttons[1] & ~MouseButtons[1];

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      shot_count <= '0;
      shot_fire  <= 1'b0;
    end else begin
      shot_fire <= 1'b0;
      if (reload) begin
        shot_count <= '0;
      end else if (fire_edge && (shot_count < 2'(MAX_SHOTS))) begin
        shot_count <= shot_count + 2'd1;
        shot_fire  <= 1'b1;
      end
    end
  end
`else
  logic unused_reload;
  assign unused_reload = reload;
  assign shot_count    = '0;
  assign shot_fire     = 1'b0;
`endif

endmodule

// File: doc/cursor_tracker.md
# cursor_tracker

Mouse-driven cursor and shot-state stage that sits directly upstream of `color_mapper`. It accepts decoded mouse reports over a valid/ready handshake and accumulates the motion. Once per frame it applies that motion to a clamped on-screen position. It produces the `BallX`/`BallY`/`Ball_size`/`MouseButtons` values the colour mapper draws from, plus a saturating shot counter with fire and reload events.

## Interface
Parameters:
- `SCREEN_W`, 640, visible width in pixels
- `SCREEN_H`, 480, visible height in pixels
- `CURSOR_SIZE`, 4, cursor half-extent; driven on `Ball_size`
- `START_X`, 320, reset X position
- `START_Y`, 240, reset Y position
- `MAX_SHOTS`, 3, shot counter ceiling

Ports:
- `Clk`  in  1  system clock; the only clock
- `Reset`  in  1  asynchronous, active-low reset
- `frame_clk`  in  1  vsync from the VGA controller; asynchronous, synchronized internally
- `report_valid`  in  1  mouse report present
- `report_ready`  out  1  block can accept a report
- `report_dx`  in  8  signed X delta; positive = right
- `report_dy`  in  8  signed Y delta; positive = up
- `report_buttons`  in  8  button bitmap: bit0 = left, bit1 = right
- `reload`  in  1  one-cycle pulse; refills shots
- `BallX`, `BallY`  out  10  cursor centre
- `Ball_size`  out  10  constant `CURSOR_SIZE`
- `MouseButtons`  out  8  last accepted button bitmap
- `shot_count`  out  2  shots used, 0..`MAX_SHOTS`
- `shot_fire`  out  1  one-cycle pulse per accepted shot

## Operation
- Reset values:
  - `BallX` = `START_X`, `BallY` = `START_Y`
  - `MouseButtons` = 0, `shot_count` = 0, `shot_fire` = 0
  - `report_ready` = 1; accumulators = 0; state IDLE
- FSM has two states:
  - IDLE: accepts reports; moves to APPLY when a frame edge is detected.
  - APPLY: lasts one cycle, then returns to IDLE.
- `report_ready` = (state == IDLE).
- A transfer happens on a cycle with `report_valid & report_ready`.
- On each transfer:
  - `acc_x += sext(dx)` and `acc_y -= sext(dy)`; the Y inversion makes screen Y grow downward.
  - Accumulators are 11-bit signed and saturate at −1024 and +1023; they never wrap.
  - A transfer on the same cycle as the frame edge is included in that frame's update.
- APPLY cycle:
  - `sum = {2'b0, BallX} + sext(acc_x)`, computed at 12-bit signed.
  - Clamp `sum` to [`CURSOR_SIZE`, `SCREEN_W`−1−`CURSOR_SIZE`]; Y is handled the same way against `SCREEN_H`.
  - Both accumulators clear.
- Button handling:
  - `MouseButtons` registers `report_buttons` on each transfer.
  - A right-button rising edge is bit1 going 0→1 between consecutive accepted reports.
  - If a rising edge arrives while `shot_count` < `MAX_SHOTS`: increment `shot_count` and pulse `shot_fire`.
  - If `shot_count` is already at `MAX_SHOTS`, the edge is ignored (no pulse).
  - A held button never refires.
- `reload` clears `shot_count` to 0. If `reload` and a fire edge occur on the same cycle, `reload` wins: count = 0 and there is no pulse.
- Reset asserted mid-frame: all state returns to reset values immediately, and any pending motion is discarded.

## Timing
- `frame_clk` passes through a 2-flop synchronizer plus a rising-edge detect.
- `BallX`/`BallY` update 3 `Clk` cycles after the first `Clk` edge that samples `frame_clk` high, giving at most one update per frame.
- `MouseButtons`, `shot_count` and `shot_fire` update on the cycle after the transfer.
- `report_ready` is low for exactly one cycle per frame, during APPLY.
- All outputs are registered.

## Configuration
- `CURSOR_SHOTS_EN`:
  - Defined: shot counter, edge detect, `reload` and `shot_fire` are implemented as above.
  - Undefined: `shot_count` ties to 0 and `shot_fire` ties to 0; `reload` is ignored.
  - Cursor motion and `MouseButtons` behave identically in both builds.

## Structure
- `cursor_pkg` holds:
  - the state enum (IDLE, APPLY)
  - screen-dimension constants
  - accumulator width (11) and saturation limits
  - a clamp function
- One sub-module, `edge_sync`: 2-flop synchronizer plus rising-edge pulse, instantiated for `frame_clk`.

## Test plan
- Reset release, no reports → `BallX` = 320, `BallY` = 240, `report_ready` = 1, `shot_count` = 0.
- Three reports with dx = +10 and dy = +5, then a frame edge → `BallX` = 350, `BallY` = 225, exactly 3 cycles after the sampled edge; accumulators are 0 afterwards.
- Twenty reports with dx = −128 (saturates at −1024), then a frame edge → `BallX` = 4; a later dx = +127 frame → `BallX` = 131.
- Right-button sequence 0→2→0→2→0→2→0→2 → `shot_fire` pulses three times, `shot_count` stops at 3, fourth edge has no pulse; button held at 2 for 5 reports → no extra pulses.
- `reload` on the same cycle as a fire edge with count = 1 → count = 0, no `shot_fire`.
- Frame edge coincident with `report_valid` (dx = +1) → delta included in that frame (`BallX` += 1); `report_ready` low for only the APPLY cycle; `Reset` pulsed low mid-frame → `BallX` = 320 and pending delta dropped.
